// File: rtl/connect4_pkg.sv
// Shared types and constants for the 4x4 Connect-4 turn controller.
package connect4_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam logic [COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_MOVE,
    ISSUE,
    WAIT_ACK,
    CHECK,
    GAME_OVER
  } state_t;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_P1      = 2'b01,
    GS_P2      = 2'b10,
    GS_DRAW    = 2'b11
  } game_status_t;

  // Gameboard bit index of the top cell of a column.
  function automatic int top_bit(input int col);
    return (ROWS - 1) * COLS + col;
  endfunction

endpackage

// File: rtl/c4_press_decoder.sv
// Turns one player's active-low column buttons into a registered single-cycle press strobe.
module c4_press_decoder
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic       press_valid,
  output logic [1:0] press_col
);

  logic [3:0] prev;
  logic       one_low;
  logic [1:0] low_col;

  always_comb begin
    one_low = 1'b0;
    low_col = 2'd0;
    case (col_n)
      4'b1110: begin one_low = 1'b1; low_col = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_col = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_col = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_col = 2'd3; end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev        <= COL_IDLE;
      press_valid <= 1'b0;
      press_col   <= 2'd0;
    end else begin
      prev        <= col_n;
      press_valid <= (prev == COL_IDLE) && one_low;
      press_col   <= low_col;
    end
  end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect-4 turn sequencer: arbitrates presses, strobes the column FSM, confirms moves, times turns.
module connect4_turn_controller
  import connect4_pkg::*;
#(
  parameter int TURN_CYCLES = 1000,
  parameter int ACK_CYCLES  = 8,
  parameter int CLR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  p1_col_n,
  input  logic [3:0]  p2_col_n,
  input  logic        new_game,
  input  logic [15:0] gameboard,
  input  logic [1:0]  game_status,
  output logic        fsm_enable,
  output logic [3:0]  fsm_column,
  output logic        fsm_reset,
  output logic        turn,
  output logic [4:0]  move_count,
  output logic        illegal_move,
  output logic        auto_move,
  output logic        game_over
);

  localparam int TURN_W = $clog2(TURN_CYCLES + 1);
  localparam int ACK_W  = $clog2(ACK_CYCLES + 1);
  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);
  localparam logic [4:0] MAX_MOVES = 5'(COLS * ROWS);

  state_t            state;
  logic [TURN_W-1:0] turn_timer;
  logic [ACK_W-1:0]  ack_timer;
  logic [CLR_W-1:0]  clr_timer;
  logic [15:0]       snapshot;

  logic       p1_valid, p2_valid;
  logic [1:0] p1_col, p2_col;
  logic       sel_valid;
  logic [1:0] sel_col;
  logic [COLS-1:0] col_full;
  logic       free_any;
  logic [1:0] free_col;
  logic       timeout;

  c4_press_decoder u_p1_dec (
    .clk        (clk),
    .reset      (reset),
    .col_n      (p1_col_n),
    .press_valid(p1_valid),
    .press_col  (p1_col)
  );

  c4_press_decoder u_p2_dec (
    .clk        (clk),
    .reset      (reset),
    .col_n      (p2_col_n),
    .press_valid(p2_valid),
    .press_col  (p2_col)
  );

  // Only the player whose turn it is can be heard.
  assign sel_valid = turn ? p2_valid : p1_valid;
  assign sel_col   = turn ? p2_col   : p1_col;
  assign col_full  = gameboard[top_bit(0) +: COLS];
  assign timeout   = (turn_timer == TURN_W'(TURN_CYCLES - 1));

  always_comb begin
    free_any = 1'b0;
    free_col = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_full[c]) begin
        free_any = 1'b1;
        free_col = 2'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CLEAR;
      fsm_enable   <= 1'b0;
      fsm_column   <= COL_IDLE;
      fsm_reset    <= 1'b1;
      turn         <= 1'b0;
      move_count   <= 5'd0;
      illegal_move <= 1'b0;
      auto_move    <= 1'b0;
      game_over    <= 1'b0;
      turn_timer   <= '0;
      ack_timer    <= '0;
      clr_timer    <= '0;
      snapshot     <= '0;
    end else begin
      // NOTE: strobes default low every cycle; only the cycle that asserts them sets them.
      fsm_enable   <= 1'b0;
      illegal_move <= 1'b0;
      auto_move    <= 1'b0;

      if (new_game) begin
        state      <= CLEAR;
        fsm_reset  <= 1'b1;
        fsm_column <= COL_IDLE;
        game_over  <= 1'b0;
        turn       <= 1'b0;
        move_count <= 5'd0;
        turn_timer <= '0;
        ack_timer  <= '0;
        clr_timer  <= '0;
      end else begin
        case (state)
          CLEAR: begin
            if (clr_timer == CLR_W'(CLR_CYCLES - 1)) begin
              fsm_reset  <= 1'b0;
              turn       <= 1'b0;
              move_count <= 5'd0;
              turn_timer <= '0;
              state      <= WAIT_MOVE;
            end else begin
              clr_timer <= clr_timer + 1'b1;
            end
          end

          WAIT_MOVE: begin
            if (sel_valid && !col_full[sel_col]) begin
              fsm_enable <= 1'b1;
              fsm_column <= ~(4'b0001 << sel_col);
              state      <= ISSUE;
            end else begin
              if (sel_valid) illegal_move <= 1'b1;
              if (timeout) begin
                if (free_any) begin
                  fsm_enable <= 1'b1;
                  auto_move  <= 1'b1;
                  fsm_column <= ~(4'b0001 << free_col);
                  state      <= ISSUE;
                end else begin
                  game_over <= 1'b1;
                  state     <= GAME_OVER;
                end
              end else begin
                turn_timer <= turn_timer + 1'b1;
              end
            end
          end

          // Strobe is already out; capture the board the strobe will modify.
          ISSUE: begin
            snapshot   <= gameboard;
            fsm_column <= COL_IDLE;
            ack_timer  <= '0;
            state      <= WAIT_ACK;
          end

          WAIT_ACK: begin
            if (gameboard != snapshot) begin
              if (move_count != MAX_MOVES) move_count <= move_count + 5'd1;
              state <= CHECK;
            end else if (ack_timer == ACK_W'(ACK_CYCLES - 1)) begin
              illegal_move <= 1'b1;
              turn_timer   <= '0;
              state        <= WAIT_MOVE;
            end else begin
              ack_timer <= ack_timer + 1'b1;
            end
          end

          CHECK: begin
            if (game_status != GS_PLAYING) begin
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              turn       <= ~turn;
              turn_timer <= '0;
              state      <= WAIT_MOVE;
            end
          end

          GAME_OVER: game_over <= 1'b1;

          default: state <= CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller with a behavioural column-drop gameboard model.
module tb_connect4_turn_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  p1_col_n;
  logic [3:0]  p2_col_n;
  logic        new_game;
  logic [15:0] gameboard;
  logic [1:0]  game_status;
  logic        fsm_enable;
  logic [3:0]  fsm_column;
  logic        fsm_reset;
  logic        turn;
  logic [4:0]  move_count;
  logic        illegal_move;
  logic        auto_move;
  logic        game_over;

  connect4_turn_controller dut (
    .clk         (clk),
    .reset       (reset),
    .p1_col_n    (p1_col_n),
    .p2_col_n    (p2_col_n),
    .new_game    (new_game),
    .gameboard   (gameboard),
    .game_status (game_status),
    .fsm_enable  (fsm_enable),
    .fsm_column  (fsm_column),
    .fsm_reset   (fsm_reset),
    .turn        (turn),
    .move_count  (move_count),
    .illegal_move(illegal_move),
    .auto_move   (auto_move),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Gameboard model: a strobe drops a piece into the lowest free cell of the column.
  logic [15:0] model_board = '0;
  logic [15:0] extra_mask  = '0;
  bit          ack_on      = 1'b1;
  assign gameboard = model_board | extra_mask;

  function automatic logic [15:0] drop(input logic [15:0] b, input logic [3:0] coln);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      if (!coln[c])
        for (int row = 0; row < 4; row++)
          if (!b[4'(row * 4 + c)] && r == '0) r[4'(row * 4 + c)] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    logic       rst_seen, en_seen;
    logic [3:0] col_seen;
    rst_seen = fsm_reset;
    en_seen  = fsm_enable && ack_on;
    col_seen = fsm_column;
    #1;
    if (rst_seen) model_board = '0;
    else if (en_seen) model_board = model_board | drop(gameboard, col_seen);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         en_cnt = 0, ill_cnt = 0, auto_cnt = 0, auto_orphan = 0, en_cyc = 0;
  logic [3:0] last_col = 4'hF;
  always @(negedge clk) begin
    if (fsm_enable) begin
      en_cnt++;
      last_col = fsm_column;
      en_cyc   = cyc;
    end
    if (auto_move) begin
      auto_cnt++;
      if (!fsm_enable) auto_orphan++;
    end
    if (illegal_move) ill_cnt++;
  end

  int press_cyc = 0;

  task automatic apply_press(input logic [3:0] a, input logic [3:0] b, input int settle);
    @(negedge clk);
    p1_col_n  = a;
    p2_col_n  = b;
    press_cyc = cyc;
    repeat (3) @(negedge clk);
    p1_col_n = 4'hF;
    p2_col_n = 4'hF;
    repeat (settle) @(negedge clk);
  endtask

  task automatic step(input string nm, input logic [3:0] a, input logic [3:0] b, input int settle,
                      input int exp_en, input logic [3:0] exp_col, input int exp_ill,
                      input logic exp_turn, input logic [4:0] exp_count);
    int e0, i0;
    e0 = en_cnt;
    i0 = ill_cnt;
    apply_press(a, b, settle);
    check({nm, ".enables"}, en_cnt - e0, exp_en);
    if (exp_en > 0) begin
      check({nm, ".column"}, int'(last_col), int'(exp_col));
      check({nm, ".latency"}, en_cyc - press_cyc, 2);
    end
    check({nm, ".illegal"}, ill_cnt - i0, exp_ill);
    check({nm, ".turn"}, int'(turn), int'(exp_turn));
    check({nm, ".move_count"}, int'(move_count), int'(exp_count));
  endtask

  typedef struct {
    logic [3:0] p1;
    logic [3:0] p2;
    int         en;
    logic [3:0] col;
    int         ill;
    logic       turn;
    logic [4:0] count;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int e0, a0, i0, waited;

    vecs[0] = '{4'b1110, 4'b1111, 1, 4'b1110, 0, 1'b1, 5'd1};  // P1 col 0
    vecs[1] = '{4'b1101, 4'b1111, 0, 4'b1111, 0, 1'b1, 5'd1};  // P1 out of turn
    vecs[2] = '{4'b1111, 4'b1011, 1, 4'b1011, 0, 1'b0, 5'd2};  // P2 col 2
    vecs[3] = '{4'b1100, 4'b1111, 0, 4'b1111, 0, 1'b0, 5'd2};  // two bits low
    vecs[4] = '{4'b1111, 4'b0111, 0, 4'b1111, 0, 1'b0, 5'd2};  // P2 out of turn
    vecs[5] = '{4'b0111, 4'b1111, 1, 4'b0111, 0, 1'b1, 5'd3};  // P1 col 3
    vecs[6] = '{4'b1111, 4'b1110, 1, 4'b1110, 0, 1'b0, 5'd4};  // P2 col 0, row 1
    vecs[7] = '{4'b1111, 4'b1111, 0, 4'b1111, 0, 1'b0, 5'd4};  // idle
    vecs[8] = '{4'b1101, 4'b1110, 1, 4'b1101, 0, 1'b1, 5'd5};  // both press, P1 has turn

    p1_col_n    = 4'hF;
    p2_col_n    = 4'hF;
    new_game    = 1'b0;
    game_status = 2'b00;
    reset       = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst.fsm_reset", int'(fsm_reset), 1);
    check("rst.fsm_enable", int'(fsm_enable), 0);
    check("rst.fsm_column", int'(fsm_column), 'hF);
    check("rst.turn", int'(turn), 0);
    check("rst.move_count", int'(move_count), 0);
    check("rst.pulses", int'({illegal_move, auto_move, game_over}), 0);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("clear.fsm_reset_cycle1", int'(fsm_reset), 1);
    @(posedge clk); #1;
    check("clear.fsm_reset_cycle2_done", int'(fsm_reset), 0);
    check("clear.turn", int'(turn), 0);
    check("clear.fsm_column", int'(fsm_column), 'hF);
    repeat (5) @(negedge clk);
    check("idle.no_enable", en_cnt, 0);

    for (int i = 0; i < 9; i++)
      step($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, 16, vecs[i].en, vecs[i].col,
           vecs[i].ill, vecs[i].turn, vecs[i].count);

    // Turn timeout with column 0 full: auto-move into column 1.
    extra_mask = 16'h1111;
    e0 = en_cnt;
    a0 = auto_cnt;
    waited = 0;
    while (en_cnt == e0 && waited < 1200) begin
      @(negedge clk);
      waited++;
    end
    check("timeout.enables", en_cnt - e0, 1);
    check("timeout.column", int'(last_col), 'b1101);
    check("timeout.auto_move", auto_cnt - a0, 1);
    check("timeout.not_early", int'(waited > 900), 1);
    repeat (10) @(negedge clk);
    check("timeout.move_count", int'(move_count), 6);
    check("timeout.turn", int'(turn), 0);

    step("p1_col2", 4'b1011, 4'hF, 16, 1, 4'b1011, 0, 1'b1, 5'd7);

    // Column 1 full: P2 press is rejected.
    extra_mask = extra_mask | 16'h2222;
    step("full_col", 4'hF, 4'b1101, 16, 0, 4'hF, 1, 1'b1, 5'd7);

    // No board change after the strobe: ack timeout.
    ack_on = 1'b0;
    step("ack_timeout", 4'hF, 4'b0111, 20, 1, 4'b0111, 1, 1'b1, 5'd7);
    ack_on = 1'b1;

    // Winning move, then presses are ignored.
    game_status = 2'b01;
    step("win", 4'hF, 4'b0111, 16, 1, 4'b0111, 0, 1'b1, 5'd8);
    check("win.game_over", int'(game_over), 1);
    step("over_ignored", 4'b1110, 4'b1110, 10, 0, 4'hF, 0, 1'b1, 5'd8);
    check("over.still_game_over", int'(game_over), 1);

    @(negedge clk);
    extra_mask  = '0;
    game_status = 2'b00;
    new_game    = 1'b1;
    @(posedge clk); #1;
    check("new_game.fsm_reset", int'(fsm_reset), 1);
    check("new_game.game_over", int'(game_over), 0);
    @(negedge clk);
    new_game = 1'b0;
    repeat (4) @(negedge clk);
    check("new_game.fsm_reset_done", int'(fsm_reset), 0);
    check("new_game.move_count", int'(move_count), 0);
    check("new_game.turn", int'(turn), 0);
    step("post_new_game", 4'b1110, 4'hF, 16, 1, 4'b1110, 0, 1'b1, 5'd1);

    // Asynchronous reset while the enable strobe is high.
    @(negedge clk);
    p2_col_n = 4'b1011;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_move.enable_high", int'(fsm_enable), 1);
    check("mid_move.column", int'(fsm_column), 'b1011);
    #2 reset = 1'b0;
    #1;
    check("mid_move_rst.fsm_enable", int'(fsm_enable), 0);
    check("mid_move_rst.fsm_column", int'(fsm_column), 'hF);
    check("mid_move_rst.fsm_reset", int'(fsm_reset), 1);
    check("mid_move_rst.move_count", int'(move_count), 0);
    p2_col_n = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("auto_without_enable", auto_orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
